fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the core. It replaces the
//  PC register, the ROM read and the IF/ID register with a DEPTH-entry
//  prefetch queue. It keeps the synchronous instruction ROM busy while
//  decode holds, and flushes on redirect. Decode consumes {inst, inst_addr}
//  from the queue head. Execute drives jump_en/jump_addr and hold_en.
// PARAMETERS
//  ADDR_W    32  width of PC / ROM address
//  INST_W    32  instruction width; PC step = INST_W/8
//  DEPTH      4  queue entries; power of 2, >= 2
//  RESET_PC   0  PC value loaded on reset
// PORTS
//  sys_clk    in   1        core clock; all state on rising edge
//  sys_rst    in   1        reset, asynchronous, active-high
//  jump_en    in   1        redirect request from execute
//  jump_addr  in   ADDR_W   redirect target
//  hold_en    in   1        decode stall; head must not be popped
//  rom_ren    out  1        ROM read strobe (combinational)
//  rom_addr   out  ADDR_W   ROM read address = pc (combinational)
//  rom_data   in   INST_W   ROM data, valid 1 cycle after rom_ren
//  inst_valid out  1        queue head valid
//  inst       out  INST_W   head instruction; NOP (0x00000013) when empty
//  inst_addr  out  ADDR_W   head instruction address; 0 when empty
//  count      out  $clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  - Reset: pc=RESET_PC, queue empty, count=0, in-flight flag clear.
//    inst_valid=0, inst=NOP, inst_addr=0. rom_ren=0 while sys_rst is high.
//  - pop  = inst_valid & ~hold_en & ~jump_en.
//  - issue = ~jump_en & ((count + inflight) < DEPTH | pop).
//    On issue: rom_ren=1, rom_addr=pc. At the edge: pc<=pc+INST_W/8
//    (wraps modulo 2^ADDR_W), inflight<=1, inflight_addr<=pc.
//    Otherwise inflight<=0.
//  - push = inflight & ~jump_en. At the edge, push writes
//    {inflight_addr, rom_data} at the tail.
//  - Show-ahead head: inst, inst_addr and inst_valid come from registered
//    storage. Issue-to-inst_valid latency is 2 cycles. After reset release,
//    the first instruction (RESET_PC) appears 2 cycles after the first issue.
//  - Push and pop in the same cycle are allowed at any occupancy, including
//    full; count is unchanged.
//  - The credit rule (count + inflight) never lets a push overflow. No
//    overflow or underflow state is reachable. An assertion checks
//    count <= DEPTH.
//  - Redirect (jump_en=1) overrides hold, issue, push and pop. At the edge:
//    pc<=jump_addr, queue emptied, count<=0, inflight<=0. Any ROM data
//    returning in that cycle is discarded.
//    The target is issued in cycle J+1. The target is at the head with
//    inst_valid=1 in cycle J+3.
//  - jump_en together with hold_en: the redirect still flushes.
//  - jump_en in consecutive cycles: the last target wins.
//  - hold_en with an empty queue has no effect beyond blocking pop.
//  - Reset asserted mid-operation returns everything to reset values
//    immediately (async). In-flight ROM data is ignored.
// STRUCTURE
//  - Shared defines header (core-wide): INST_NOP = 32'h00000013,
//    RESET_PC default, address/instruction widths.
//  - One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/flush,
//    show-ahead head, count). It is instantiated with
//    WIDTH = ADDR_W + INST_W and holds {addr, inst}.
//  - The top level holds pc, the in-flight flag/address, issue/credit logic
//    and output muxing (NOP when empty).
// TESTING
//  1 Reset release with hold_en=0, ROM word i = i: inst_valid rises 2 cycles
//    after the first rom_ren. inst_addr sequence 0,4,8,...; inst 0,1,2,...
//  2 hold_en=1 for 10 cycles: count saturates at 4. rom_ren drops when
//    count + inflight = 4. Head stays at the same addr. On release, the
//    next 4 addrs pop back-to-back with no gap.
//  3 jump_en=1 with jump_addr=0x100 while the queue holds 3 entries:
//    next cycle count=0 and inst=NOP. rom_addr=0x100 in J+1. Head
//    addr=0x100 valid in J+3.
//  4 jump_en and hold_en together on a full queue: flush takes priority.
//    The target appears at J+3.
//  5 jump_en in two consecutive cycles (0x200, then 0x300): only 0x300 and
//    its successors reach the head. No 0x200 entry ever becomes valid.
//  6 RESET_PC=0xFFFFFFF8: after 0xFFFFFFFC the next addr is 0x00000000.
//    sys_rst pulsed mid-stream clears count and inst_valid in the same
//    cycle, with no clock edge needed.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
//   Core-wide defines shared by the fetch front end: the canonical NOP
//   encoding (addi x0,x0,0), the default reset PC and the default
//   address / instruction widths.
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int unsigned FQ_ADDR_W   = 32;
   localparam int unsigned FQ_INST_W   = 32;
   localparam int unsigned FQ_DEPTH    = 4;
   localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FQ_INST_NOP = 32'h0000_0013;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_chk.sv
// ----------------------------------------------------------------------------
// fetch_queue_chk
//   Invariant checker for the fetch queue: occupancy never exceeds DEPTH.
// Ports
//   clk    in   1       clock, rising edge
//   rst    in   1       asynchronous active-high reset
//   count  in   CNT_W   queue occupancy
// ----------------------------------------------------------------------------
module fetch_queue_chk #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input logic             clk,
   input logic             rst,
   input logic [CNT_W-1:0] count
);

   // Occupancy bound guaranteed by the issue credit rule.
   a_count_le_depth : assert property (
      @(posedge clk) disable iff (rst) (int'(count) <= int'(DEPTH))
   );

endmodule : fetch_queue_chk

// File: rtl/fetch_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO. The head entry is always presented on
//   rdata straight from registered storage, so a pop simply advances the
//   read pointer. flush empties the FIFO and wins over push and pop.
//   Push and pop in the same cycle are legal at any occupancy, including
//   full: the slot being overwritten is the one being popped.
// Ports
//   clk    in   1       clock, rising edge
//   rst    in   1       asynchronous active-high reset
//   push   in   1       write wdata at the tail
//   pop    in   1       discard the head entry
//   flush  in   1       empty the FIFO (overrides push/pop)
//   wdata  in   WIDTH   tail write data
//   rdata  out  WIDTH   head entry (stale content when empty)
//   count  out  CNT_W   entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Next-state computation for pointers, occupancy and storage.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared on reset so the head is never X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule : sync_fifo

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end: PC register, ROM read issue and a
//   DEPTH-entry prefetch queue whose head feeds decode. The ROM keeps being
//   read while decode holds, as long as there is credit for the returning
//   word (queued entries + the one in flight < DEPTH, or a pop frees a slot
//   this cycle). A redirect flushes the queue and drops any in-flight data.
// Ports
//   sys_clk    in   1        clock, rising edge
//   sys_rst    in   1        asynchronous active-high reset
//   jump_en    in   1        redirect request
//   jump_addr  in   ADDR_W   redirect target
//   hold_en    in   1        decode stall, head is not popped
//   rom_ren    out  1        ROM read strobe (combinational)
//   rom_addr   out  ADDR_W   ROM read address = pc (combinational)
//   rom_data   in   INST_W   ROM data, one cycle after rom_ren
//   inst_valid out  1        head valid
//   inst       out  INST_W   head instruction, NOP when empty
//   inst_addr  out  ADDR_W   head instruction address, 0 when empty
//   count      out  CNT_W    entries held
// ----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned        ADDR_W   = FQ_ADDR_W,
   parameter int unsigned        INST_W   = FQ_INST_W,
   parameter int unsigned        DEPTH    = FQ_DEPTH,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FQ_RESET_PC),
   localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              hold_en,
   output logic              rom_ren,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned       ENT_W    = ADDR_W + INST_W;
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_W / 8);
   localparam logic [INST_W-1:0] NOP_INST = INST_W'(FQ_INST_NOP);
   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

   logic [CNT_W-1:0]  fifo_count_s;
   logic [ENT_W-1:0]  head_s;
   logic [CNT_W:0]    credit_s;
   logic              head_valid_s;
   logic              pop_s;
   logic              push_s;
   logic              issue_s;

   // Handshake decode: redirect suppresses pop, push and issue.
   always_comb begin
      head_valid_s = (fifo_count_s != {CNT_W{1'b0}});
      credit_s     = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_q};
      pop_s        = head_valid_s & ~hold_en & ~jump_en;
      push_s       = inflight_q & ~jump_en;
      issue_s      = ~jump_en & ((credit_s < DEPTH_C) | pop_s);
   end

   // PC and in-flight tracking next state.
   always_comb begin
      pc_d            = pc_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      if (jump_en) begin
         pc_d       = jump_addr;
         inflight_d = 1'b0;
      end else if (issue_s) begin
         // PC wraps naturally modulo 2^ADDR_W.
         pc_d            = pc_q + PC_STEP;
         inflight_d      = 1'b1;
         inflight_addr_d = pc_q;
      end else begin
         inflight_d = 1'b0;
      end
   end

   // PC / in-flight registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pc_q            <= RESET_PC;
         inflight_q      <= 1'b0;
         inflight_addr_q <= {ADDR_W{1'b0}};
      end else begin
         pc_q            <= pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (push_s),
      .pop   (pop_s),
      .flush (jump_en),
      .wdata ({inflight_addr_q, rom_data}),
      .rdata (head_s),
      .count (fifo_count_s)
   );

   fetch_queue_chk #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .count (fifo_count_s)
   );

   // Output muxing: ROM strobe is forced low during reset, head shows NOP/0 when empty.
   always_comb begin
      rom_ren    = issue_s & ~sys_rst;
      rom_addr   = pc_q;
      inst_valid = head_valid_s;
      count      = fifo_count_s;
      if (head_valid_s) begin
         inst      = head_s[INST_W-1:0];
         inst_addr = head_s[ENT_W-1:INST_W];
      end else begin
         inst      = NOP_INST;
         inst_addr = {ADDR_W{1'b0}};
      end
   end

endmodule : fetch_queue
